// File: rtl/sign_extend_16_32_if.sv
`default_nettype none
// ============================================================================
// Module   : sign_extend_16_32_if
// Purpose  : Valid/ready bus bundle for the 16->32 immediate extender.
// Revision : 1.0 - initial release
// ============================================================================
interface sign_extend_16_32_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  Entrada;
   logic             Signo;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] Salida;
   logic             Negativo;
   logic             Cero;

   modport master (
      output in_valid, Entrada, Signo, out_ready,
      input  in_ready, out_valid, Salida, Negativo, Cero
   );

   modport slave (
      input  in_valid, Entrada, Signo, out_ready,
      output in_ready, out_valid, Salida, Negativo, Cero
   );
endinterface
`default_nettype wire

// File: rtl/sign_extend_16_32.sv
`default_nettype none
// ============================================================================
// Module   : sign_extend_16_32
// Purpose  : Sign/zero-extends a 16-bit immediate into a 2-entry result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sign_extend_16_32 #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   sign_extend_16_32_if.slave bus
);
   localparam logic [1:0] c_DEPTH = 2'd2;

   logic [OUT_W-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             r_in_ready;

   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;
   logic [1:0]       w_count_nxt;
   logic [OUT_W-1:0] w_ext;
   logic [OUT_W-1:0] w_head;

   assign w_ext       = {{(OUT_W-IN_W){bus.Signo & bus.Entrada[IN_W-1]}}, bus.Entrada};
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid & r_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // in_ready is registered from the post-edge occupancy so it never depends
   // combinationally on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_ext;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt < c_DEPTH);
      end
   end

   // Flags come from the stored head word, masked to zero when nothing is held.
   assign w_head        = w_out_valid ? r_mem[r_rd_ptr] : '0;
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.Salida    = w_head;
   assign bus.Negativo  = w_head[OUT_W-1];
   assign bus.Cero      = (w_head == '0);
endmodule
`default_nettype wire

// File: tb/tb_sign_extend_16_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_extend_16_32
// Purpose  : Randomized and directed checks of sign_extend_16_32 against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_extend_16_32;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic exp_rdy;
   logic [31:0] q[$];

   sign_extend_16_32_if bus ();

   sign_extend_16_32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input logic [15:0] e, input logic s);
      if (s && e >= 16'h8000) return 32'hFFFF_0000 + {16'h0, e};
      return {16'h0, e};
   endfunction

   task automatic check_outputs(input string tag);
      logic [31:0] want;
      want = (q.size() != 0) ? q[0] : 32'h0;
      check({tag, ".in_ready"},  {31'b0, bus.in_ready},  {31'b0, exp_rdy});
      check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
      check({tag, ".Salida"},    bus.Salida, want);
      check({tag, ".Negativo"},  {31'b0, bus.Negativo}, {31'b0, want >= 32'h8000_0000});
      check({tag, ".Cero"},      {31'b0, bus.Cero},     {31'b0, want == 32'h0});
   endtask

   // Called just after a rising edge; checks mid-cycle, then advances one edge.
   task automatic step(input logic iv, input logic [15:0] e, input logic s, input logic ordy);
      logic push, pop;
      bus.in_valid  = iv;
      bus.Entrada   = e;
      bus.Signo     = s;
      bus.out_ready = ordy;
      @(negedge clk);
      check_outputs("cyc");
      push = rst_n && iv && exp_rdy;
      pop  = rst_n && (q.size() != 0) && ordy;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ext(e, s));
      exp_rdy = rst_n && (q.size() < 2);
      @(posedge clk);
      #1;
   endtask

   logic [15:0] vec [6];

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_rdy  = 1'b0;
      rst_n    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.Entrada   = 16'h0;
      bus.Signo     = 1'b0;
      bus.out_ready = 1'b0;
      vec[0] = 16'h0000; vec[1] = 16'h8001; vec[2] = 16'hB71E;
      vec[3] = 16'hAAAA; vec[4] = 16'hFF00; vec[5] = 16'hFFFF;

      #2;
      check_outputs("reset");
      @(posedge clk); #1;
      step(1'b1, 16'h1234, 1'b1, 1'b1);
      rst_n = 1'b1;
      step(1'b1, 16'h1234, 1'b1, 1'b1);

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 6; i++) step(1'b1, vec[i], s[0], 1'b1);
         step(1'b0, 16'h0, 1'b0, 1'b1);
         step(1'b0, 16'h0, 1'b0, 1'b1);
      end
      step(1'b1, 16'h7FFF, 1'b1, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b1);

      // Back-pressure: fill both slots, try a third push, then drain in order.
      step(1'b1, 16'h8001, 1'b1, 1'b0);
      step(1'b1, 16'hAAAA, 1'b0, 1'b0);
      step(1'b1, 16'h5555, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b1, 16'h9999, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

      // Mid-stream reset with two entries held.
      step(1'b1, 16'hC001, 1'b1, 1'b0);
      step(1'b1, 16'h0042, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      exp_rdy = 1'b0;
      check_outputs("async_rst");
      @(posedge clk); #1;
      step(1'b1, 16'h7777, 1'b0, 1'b1);
      rst_n = 1'b1;
      step(1'b1, 16'h7777, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, 16'($urandom), 1'($urandom), ($urandom % 3) != 0);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sign_extend_16_32.md
SIGN_EXTEND_16_32 -- requirements
Module: sign_extend_16_32

Interface
REQ-001 The block SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Parameter: IN_W, default 16, input field width; the block SHALL be verified only at this default.
REQ-003 Parameter: OUT_W, default 32, output word width; the block SHALL be verified only at this default.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  producer presents a transfer on Entrada/Signo.
REQ-007 in_ready  output  1  block can accept a transfer this cycle (registered).
REQ-008 Entrada  input  16  immediate to be extended.
REQ-009 Signo  input  1  1 = sign extension, 0 = zero extension; sampled together with Entrada.
REQ-010 out_valid  output  1  Salida/flags hold a valid result.
REQ-011 out_ready  input  1  consumer accepts the current result.
REQ-012 Salida  output  32  extended result.
REQ-013 Negativo  output  1  equals Salida[31] of the presented result.
REQ-014 Cero  output  1  1 when the presented Salida is all zeros.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-016 For each accepted transfer: Salida[15:0]=Entrada; Salida[31:16]=16 copies of Entrada[15] if Signo=1, else 16'h0000.
REQ-017 Latency: a result accepted at edge N SHALL appear with out_valid=1 after edge N, i.e. 1 cycle, when the buffer is empty.
REQ-018 The block SHALL contain a 2-entry FIFO/skid buffer of computed results; in_ready SHALL be 1 exactly when fewer than 2 entries are held, evaluated from registered state.
REQ-019 Results SHALL leave in acceptance order; none may be dropped or duplicated.
REQ-020 While out_valid=1 and out_ready=0, Salida, Negativo and Cero SHALL hold stable.
REQ-021 Simultaneous input and output transfer on the same edge SHALL keep occupancy unchanged and be legal at occupancy 1 or 2.
REQ-022 At occupancy 2 with out_ready=1, in_ready SHALL be 0 that cycle and return to 1 after the edge, allowing no accept while full.
REQ-023 in_valid with in_ready=0 SHALL have no effect; the producer must hold its data.
REQ-024 When out_valid=0, Salida SHALL read 32'h0, Negativo 0 and Cero 1.
REQ-025 Negativo and Cero SHALL be derived from the stored word, not recomputed from current inputs.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, clear both buffer entries, occupancy, out_valid and Salida to 0, and drive in_ready=0.
REQ-027 in_ready SHALL rise on the first rising edge after rst_n deasserts; no transfer is accepted while rst_n=0.
REQ-028 Reset asserted mid-stream SHALL discard all buffered results; none may appear after release.

Verification
REQ-029 Signo=0, Entrada 0000/8001/B71E/AAAA/FF00/FFFF, out_ready=1 -> Salida 00000000/00008001/0000B71E/0000AAAA/0000FF00/0000FFFF, each 1 cycle after acceptance; Cero=1 only for the first.
REQ-030 Signo=1, same Entrada sequence -> Salida 00000000/FFFF8001/FFFFB71E/FFFFAAAA/FFFFFF00/FFFFFFFF; Negativo=1 for all but the first.
REQ-031 Signo=1, Entrada=7FFF -> Salida=00007FFF, Negativo=0, Cero=0.
REQ-032 out_ready=0, push 8001 (Signo=1) then AAAA (Signo=0) -> in_ready drops to 0 after the second accept; Salida holds FFFF8001; raising out_ready yields FFFF8001 then 0000AAAA in order.
REQ-033 Continuous in_valid=1, out_ready=1 -> one result per cycle, in_ready stays 1, no bubbles.
REQ-034 Two entries buffered, assert rst_n=0 between edges -> out_valid=0, Salida=0 immediately; after release no stale data appears and in_ready=1 after the first edge.
